// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone command master: FSM states and response status codes.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_ERR     = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_status_e;

    localparam int CTR_W = 16;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles and flags the LIMIT-th one.
module wb_timeout_ctr
    import wb_cmd_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CTR_W-1:0] LAST_COUNT = CTR_W'(LIMIT - 1);

    logic [CTR_W-1:0] count_q;
    logic [CTR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is flagged during the enabled cycle that would complete LIMIT counts.
    assign expired_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator driven by a valid/ready command
// channel, returning one response (data + status) per command.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int ADR_W   = 30,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk48,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADR_W-1:0]     cmd_adr,
    input  logic [DAT_W-1:0]     cmd_dat,
    input  logic [DAT_W/8-1:0]   cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DAT_W-1:0]     rsp_dat,
    output logic [1:0]           rsp_status,
    output logic [ADR_W-1:0]     wishbone_adr,
    output logic [DAT_W-1:0]     wishbone_dat_w,
    input  logic [DAT_W-1:0]     wishbone_dat_r,
    output logic [DAT_W/8-1:0]   wishbone_sel,
    output logic                 wishbone_cyc,
    output logic                 wishbone_stb,
    output logic                 wishbone_we,
    output logic [2:0]           wishbone_cti,
    output logic [1:0]           wishbone_bte,
    input  logic                 wishbone_ack,
    input  logic                 wishbone_err,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [ADR_W-1:0]     adr_q, adr_d;
    logic [DAT_W-1:0]     datW_q, datW_d;
    logic [DAT_W/8-1:0]   sel_q, sel_d;
    logic [DAT_W-1:0]     rspDat_q, rspDat_d;
    rsp_status_e          rspStatus_q, rspStatus_d;

    logic accept;
    logic ctrEnable;
    logic timeoutExpired;

    assign accept    = (state_q == ST_IDLE) && cmd_valid;
    assign ctrEnable = (state_q == ST_BUS) && !wishbone_ack && !wishbone_err;

    wb_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk_i    (clk48),
        .rst_ni   (rst_n),
        .clear_i  (accept),
        .enable_i (ctrEnable),
        .expired_o(timeoutExpired)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        datW_d      = datW_q;
        sel_d       = sel_q;
        rspDat_d    = rspDat_q;
        rspStatus_d = rspStatus_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    adr_d   = cmd_adr;
                    datW_d  = cmd_dat;
                    sel_d   = cmd_sel;
                    we_d    = cmd_we;
                    cyc_d   = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // A terminating ack/err always beats a watchdog expiry in the same cycle.
                if (wishbone_ack || wishbone_err) begin
                    cyc_d   = 1'b0;
                    state_d = ST_RESP;
                    if (wishbone_err) begin
                        rspStatus_d = RSP_ERR;
                        rspDat_d    = '0;
                    end else begin
                        rspStatus_d = RSP_OK;
                        rspDat_d    = we_q ? '0 : wishbone_dat_r;
                    end
                end else if (timeoutExpired) begin
                    cyc_d       = 1'b0;
                    state_d     = ST_RESP;
                    rspStatus_d = RSP_TIMEOUT;
                    rspDat_d    = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            datW_q      <= '0;
            sel_q       <= '0;
            rspDat_q    <= '0;
            rspStatus_q <= RSP_OK;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            datW_q      <= datW_d;
            sel_q       <= sel_d;
            rspDat_q    <= rspDat_d;
            rspStatus_q <= rspStatus_d;
        end
    end

    // Ready is masked while reset is asserted so no command is taken during reset.
    assign cmd_ready      = (state_q == ST_IDLE) && rst_n;
    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_dat        = rspDat_q;
    assign rsp_status     = rspStatus_q;
    assign busy           = (state_q != ST_IDLE);
    assign wishbone_cyc   = cyc_q;
    assign wishbone_stb   = cyc_q;
    assign wishbone_we    = we_q;
    assign wishbone_adr   = adr_q;
    assign wishbone_dat_w = datW_q;
    assign wishbone_sel   = sel_q;
    assign wishbone_cti   = 3'b000;
    assign wishbone_bte   = 2'b00;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised bench for wb_cmd_master with a transaction-level reference model
// and a behavioural Wishbone slave.
module tb_wb_cmd_master;

    localparam int ADR_W = 30;
    localparam int DAT_W = 32;
    localparam int SEL_W = DAT_W / 8;
    localparam int TO    = 8;

    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_BOTH   = 2;
    localparam int K_SILENT = 3;

    logic               clk48 = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_we = 1'b0;
    logic [ADR_W-1:0]   cmd_adr = '0;
    logic [DAT_W-1:0]   cmd_dat = '0;
    logic [SEL_W-1:0]   cmd_sel = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [DAT_W-1:0]   rsp_dat;
    logic [1:0]         rsp_status;
    logic [ADR_W-1:0]   wishbone_adr;
    logic [DAT_W-1:0]   wishbone_dat_w;
    logic [DAT_W-1:0]   wishbone_dat_r = '0;
    logic [SEL_W-1:0]   wishbone_sel;
    logic               wishbone_cyc;
    logic               wishbone_stb;
    logic               wishbone_we;
    logic [2:0]         wishbone_cti;
    logic [1:0]         wishbone_bte;
    logic               wishbone_ack = 1'b0;
    logic               wishbone_err = 1'b0;
    logic               busy;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk48 = ~clk48;

    wb_cmd_master #(
        .ADR_W  (ADR_W),
        .DAT_W  (DAT_W),
        .TIMEOUT(TO)
    ) dut (
        .clk48         (clk48),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_adr       (cmd_adr),
        .cmd_dat       (cmd_dat),
        .cmd_sel       (cmd_sel),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_dat       (rsp_dat),
        .rsp_status    (rsp_status),
        .wishbone_adr  (wishbone_adr),
        .wishbone_dat_w(wishbone_dat_w),
        .wishbone_dat_r(wishbone_dat_r),
        .wishbone_sel  (wishbone_sel),
        .wishbone_cyc  (wishbone_cyc),
        .wishbone_stb  (wishbone_stb),
        .wishbone_we   (wishbone_we),
        .wishbone_cti  (wishbone_cti),
        .wishbone_bte  (wishbone_bte),
        .wishbone_ack  (wishbone_ack),
        .wishbone_err  (wishbone_err),
        .busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Transaction-level expectation: the slave answers on cycle (delay+1) of cyc,
    // unless the watchdog has already given up after TO cycles.
    function automatic void predict(input int kind, input int delay, input logic we,
                                    input logic [DAT_W-1:0] rdata, output int cycles,
                                    output logic [1:0] status, output logic [DAT_W-1:0] data);
        if (kind == K_SILENT || delay + 1 > TO) begin
            cycles = TO;
            status = 2'b10;
            data   = '0;
        end else begin
            cycles = delay + 1;
            status = (kind == K_ACK) ? 2'b00 : 2'b01;
            data   = (kind == K_ACK && !we) ? rdata : '0;
        end
    endfunction

    task automatic applyStimulus(input logic we, input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] dat,
                                 input logic [SEL_W-1:0] sel, input int kind, input int delay,
                                 input logic [DAT_W-1:0] rdata, input int readyDelay);
        int               expCycles;
        int               cycCount;
        logic [1:0]       expStatus;
        logic [DAT_W-1:0] expDat;
        logic             hit;
        predict(kind, delay, we, rdata, expCycles, expStatus, expDat);
        @(negedge clk48);
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        checkOutput("busy_idle", busy, 0);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(posedge clk48);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_adr   = ADR_W'($urandom);
        cmd_dat   = $urandom;
        cmd_sel   = SEL_W'($urandom);
        cycCount  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk48);
            if (!wishbone_cyc) break;
            cycCount++;
            checkOutput("bus_stb", wishbone_stb, 1);
            checkOutput("bus_adr", wishbone_adr, adr);
            checkOutput("bus_dat_w", wishbone_dat_w, dat);
            checkOutput("bus_sel", wishbone_sel, sel);
            checkOutput("bus_we", wishbone_we, we);
            checkOutput("bus_cmd_ready", cmd_ready, 0);
            checkOutput("bus_busy", busy, 1);
            hit = (kind != K_SILENT) && (cycCount == delay + 1);
            wishbone_ack   = hit && (kind != K_ERR);
            wishbone_err   = hit && (kind != K_ACK);
            wishbone_dat_r = hit ? rdata : $urandom;
        end
        wishbone_ack = 1'b0;
        wishbone_err = 1'b0;
        checkOutput("cyc_cycles", cycCount, expCycles);
        checkOutput("stb_after", wishbone_stb, 0);
        checkOutput("cti", wishbone_cti, 0);
        checkOutput("bte", wishbone_bte, 0);
        for (int w = 0; w <= readyDelay; w++) begin
            if (w > 0) @(negedge clk48);
            checkOutput("rsp_valid", rsp_valid, 1);
            checkOutput("rsp_status", rsp_status, expStatus);
            checkOutput("rsp_dat", rsp_dat, expDat);
            checkOutput("rsp_cmd_ready", cmd_ready, 0);
            checkOutput("rsp_cyc", wishbone_cyc, 0);
            if (w == readyDelay) begin
                rsp_ready    = 1'b1;
                cmd_valid    = 1'b0;
                wishbone_ack = 1'b0;
                wishbone_err = 1'b0;
            end else begin
                // Stray slave strobes and new commands must be ignored while a response waits.
                rsp_ready      = 1'b0;
                cmd_valid      = 1'b1;
                wishbone_ack   = 1'($urandom);
                wishbone_err   = 1'($urandom);
                wishbone_dat_r = $urandom;
            end
        end
        @(negedge clk48);
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", rsp_valid, 0);
        checkOutput("post_cmd_ready", cmd_ready, 1);
        checkOutput("post_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADR_W-1:0] rAdr;
        logic [DAT_W-1:0] rDat;
        logic [SEL_W-1:0] rSel;
        int               rKind;

        rst_n = 1'b0;
        repeat (3) @(negedge clk48);
        checkOutput("reset_cyc", wishbone_cyc, 0);
        checkOutput("reset_stb", wishbone_stb, 0);
        checkOutput("reset_we", wishbone_we, 0);
        checkOutput("reset_adr", wishbone_adr, 0);
        checkOutput("reset_dat_w", wishbone_dat_w, 0);
        checkOutput("reset_sel", wishbone_sel, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_dat", rsp_dat, 0);
        checkOutput("reset_rsp_status", rsp_status, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 30'h0000_0010, 32'hDEAD_BEEF, 4'hF, K_ACK, 3, 32'h0, 0);
        applyStimulus(1'b0, 30'h0000_0004, 32'h0, 4'hF, K_ACK, 0, 32'h1234_5678, 0);
        applyStimulus(1'b0, 30'h0000_0008, 32'h0, 4'hF, K_BOTH, 1, 32'hCAFE_F00D, 0);
        applyStimulus(1'b0, 30'h0000_000C, 32'h0, 4'h3, K_ERR, 2, 32'h5555_AAAA, 0);
        applyStimulus(1'b0, 30'h0000_0020, 32'h0, 4'hF, K_SILENT, 0, 32'h0, 0);
        applyStimulus(1'b0, 30'h0000_0024, 32'h0, 4'hF, K_ACK, TO - 1, 32'h0BAD_F00D, 0);
        applyStimulus(1'b0, 30'h0000_0028, 32'h0, 4'hF, K_ACK, TO, 32'h7777_7777, 0);
        applyStimulus(1'b0, 30'h0000_002C, 32'h0, 4'hF, K_ACK, 1, 32'hA5A5_5A5A, 10);
        applyStimulus(1'b1, 30'h0000_0030, 32'h0102_0304, 4'h5, K_ACK, 0, 32'hFFFF_FFFF, 0);

        // Reset while a bus cycle is open: the transaction is dropped silently.
        @(negedge clk48);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 30'h0000_0040;
        cmd_sel   = 4'hF;
        @(posedge clk48);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk48);
        checkOutput("rstbus_cyc_before", wishbone_cyc, 1);
        @(negedge clk48);
        rst_n = 1'b0;
        @(negedge clk48);
        checkOutput("rstbus_cyc", wishbone_cyc, 0);
        checkOutput("rstbus_stb", wishbone_stb, 0);
        checkOutput("rstbus_rsp_valid", rsp_valid, 0);
        checkOutput("rstbus_cmd_ready", cmd_ready, 0);
        checkOutput("rstbus_busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk48);
            checkOutput("rstbus_after_ready", cmd_ready, 1);
            checkOutput("rstbus_after_valid", rsp_valid, 0);
        end
        applyStimulus(1'b0, 30'h0000_0044, 32'h0, 4'hF, K_ACK, 2, 32'h1357_9BDF, 1);

        for (int n = 0; n < 30; n++) begin
            rAdr  = ADR_W'($urandom);
            rDat  = $urandom;
            rSel  = SEL_W'($urandom);
            rKind = ($urandom_range(0, 9) < 6) ? K_ACK : int'($urandom_range(1, 3));
            applyStimulus(1'($urandom), rAdr, rDat, rSel, rKind, int'($urandom_range(0, 9)),
                          $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADR_W, default 30, meaning word-address width.
REQ-002 SHALL have parameter DAT_W, default 32, meaning data width; select width is DAT_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning maximum bus cycles allowed per transaction; legal range 2..65535.
REQ-004 SHALL have port clk48  in  1: sole clock; all logic on rising edge; reset is synchronous and active-low.
REQ-005 SHALL have port rst_n  in  1: synchronous active-low reset.
REQ-006 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_adr in ADR_W, cmd_dat in DAT_W, cmd_sel in DAT_W/8: command request channel.
REQ-007 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_dat out DAT_W, rsp_status out 2 (00 OK, 01 ERR, 10 TIMEOUT): response channel.
REQ-008 SHALL have wishbone_adr out ADR_W, wishbone_dat_w out DAT_W, wishbone_dat_r in DAT_W, wishbone_sel out DAT_W/8, wishbone_cyc out 1, wishbone_stb out 1, wishbone_we out 1, wishbone_cti out 3, wishbone_bte out 2, wishbone_ack in 1, wishbone_err in 1: Wishbone classic initiator port.
REQ-009 SHALL have busy out 1: high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, BUS, RESP; one transaction outstanding at most.
REQ-011 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL register adr/dat/sel/we onto bus outputs, assert cyc=stb=1 next cycle, enter BUS, clear timeout counter.
REQ-012 cmd_ready SHALL be 0 in BUS and RESP; cmd_* ignored there.
REQ-013 BUS: cyc, stb, adr, dat_w, sel, we SHALL be held stable until termination.
REQ-014 Termination sampled at clock edge: ack or err high ends the transaction; cyc and stb SHALL be low the following cycle; enter RESP.
REQ-015 ack and err high together SHALL be treated as ERR.
REQ-016 On ack with we=0, rsp_dat SHALL capture wishbone_dat_r; on write or on ERR/TIMEOUT, rsp_dat SHALL be 0.
REQ-017 Timeout counter (16 bit) SHALL increment each BUS cycle without ack/err; on the TIMEOUT-th such cycle, drop cyc/stb, status=10, enter RESP.
REQ-018 Ack/err arriving in the same cycle the counter expires SHALL win over TIMEOUT.
REQ-019 RESP: rsp_valid=1, rsp_dat/rsp_status stable until rsp_ready; on rsp_valid&rsp_ready enter IDLE (cmd_ready=1 the next cycle).
REQ-020 ack/err seen in IDLE or RESP SHALL be ignored.
REQ-021 Minimum latency: accept at edge 0, cyc high cycle 1, ack at edge 1, rsp_valid high cycle 2; peak throughput 1 command per 3 cycles.
REQ-022 wishbone_cti SHALL be constant 000 and wishbone_bte constant 00 (classic cycles only).

Reset
REQ-023 On rst_n=0 at a clock edge: state IDLE, cyc=stb=we=0, adr/dat_w/sel=0, rsp_valid=0, rsp_dat=0, rsp_status=00, counter=0, busy=0, cmd_ready=0 during reset and 1 the first cycle after.
REQ-024 Reset mid-BUS SHALL drop cyc/stb the next cycle and discard the transaction with no response.

Structure
REQ-025 Response status encodings and the FSM state enumeration SHALL live in a shared package wb_cmd_pkg.
REQ-026 Timeout counter SHALL be a separate sub-module wb_timeout_ctr (clear, enable, expired at parameterised limit).

Verification
REQ-027 Write adr=0x0000_0010, dat=0xDEAD_BEEF, sel=0xF, slave acks 3 cycles after stb -> bus holds values 4 cycles, rsp_status=00, rsp_dat=0.
REQ-028 Read adr=0x0000_0004, slave acks immediately returning 0x1234_5678 -> rsp_valid in cycle 2 after accept, rsp_dat=0x1234_5678, status=00.
REQ-029 Read with slave asserting ack and err same cycle -> status=01, rsp_dat=0, cyc low next cycle.
REQ-030 TIMEOUT=8, slave silent -> cyc high exactly 8 cycles, status=10; ack on 8th cycle instead -> status=00.
REQ-031 rsp_ready held low 10 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0 throughout; second command accepted only after handshake.
REQ-032 rst_n low during BUS -> cyc=stb=0 next cycle, no rsp_valid, next command completes normally.
